// File: rtl/ip_ram_read_server_pkg.sv
// Shared widths and FSM state encoding for the byte-read server that fronts a 16-bit word memory.
package ip_ram_read_server_pkg;

  localparam int BYTE_ADDR_W = 22;
  localparam int WORD_ADDR_W = 21;
  localparam int WORD_W      = 16;
  localparam int BYTE_W      = 8;
  localparam int TMO_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ip_ram_read_server.sv
// Serves byte reads from a 16-bit word memory with a request timeout and a one-deep pending slot.
// Optional one-word read cache is enabled by defining IP_RAM_READ_SERVER_CACHE_EN.
module ip_ram_read_server
  import ip_ram_read_server_pkg::*;
#(
  parameter logic [TMO_W-1:0]  timeout_cycles = 8'd64,
  parameter logic [BYTE_W-1:0] fill_byte      = 8'hFF
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   rd,
  output logic                   busy,
  input  logic [BYTE_ADDR_W-1:0] address,
  output logic [BYTE_W-1:0]      rdata,
  output logic                   rdata_en,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [WORD_ADDR_W-1:0] mem_address,
  input  logic [WORD_W-1:0]      mem_rdata,
  input  logic                   mem_rdata_valid
);

  function automatic logic [BYTE_W-1:0] select_byte(input logic [WORD_W-1:0] word,
                                                    input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

  state_t                 state;
  logic                   rd_q;
  logic                   pend_vld;
  logic [BYTE_ADDR_W-1:0] pend_addr;
  logic                   cur_odd;
  logic [BYTE_W-1:0]      resp_byte;
  logic [TMO_W-1:0]       tmo_cnt;

  logic                   req_edge;
  logic                   start_go;
  logic [BYTE_ADDR_W-1:0] start_addr;
  logic                   tmo_expire;
  logic                   cache_hit;
  logic [BYTE_W-1:0]      cache_byte;

  assign req_edge = rd & ~rd_q;

  // A fresh edge overrides whatever was parked in the pending slot.
  always_comb begin
    start_addr = pend_addr;
    if (req_edge) start_addr = address;
  end

  assign start_go = ((state == ST_IDLE) && req_edge) ||
                    ((state == ST_RESP) && (req_edge || pend_vld));

  assign tmo_expire = ({1'b0, tmo_cnt} + 9'd1) >= {1'b0, timeout_cycles};

`ifdef IP_RAM_READ_SERVER_CACHE_EN
  logic                   cache_vld;
  logic [WORD_ADDR_W-1:0] cache_tag;
  logic [WORD_W-1:0]      cache_data;

  assign cache_hit  = cache_vld && (cache_tag == start_addr[BYTE_ADDR_W-1:1]);
  assign cache_byte = select_byte(cache_data, start_addr[0]);

  // Only a genuine memory response fills the cache; timeouts never do.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cache_vld  <= 1'b0;
      cache_tag  <= '0;
      cache_data <= '0;
    end else if ((state == ST_WAIT) && mem_rdata_valid) begin
      cache_vld  <= 1'b1;
      cache_tag  <= mem_address;
      cache_data <= mem_rdata;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_byte = '0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      rd_q        <= 1'b0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_address <= '0;
      rdata       <= '0;
      rdata_en    <= 1'b0;
      pend_vld    <= 1'b0;
      pend_addr   <= '0;
      cur_odd     <= 1'b0;
      resp_byte   <= '0;
      tmo_cnt     <= '0;
    end else begin
      rd_q     <= rd;
      rdata_en <= 1'b0;
      // Idle next cycle only when nothing starts; pending can only live in REQ/WAIT.
      busy     <= !(((state == ST_IDLE) && !req_edge) ||
                    ((state == ST_RESP) && !start_go));

      if (req_edge && ((state == ST_REQ) || (state == ST_WAIT))) begin
        pend_vld  <= 1'b1;
        pend_addr <= address;
      end

      case (state)
        ST_IDLE: ;
        ST_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_expire) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            resp_byte <= fill_byte;
          end else if (mem_ack) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_rdata_valid) begin
            state     <= ST_RESP;
            resp_byte <= select_byte(mem_rdata, cur_odd);
          end else if (tmo_expire) begin
            state     <= ST_RESP;
            resp_byte <= fill_byte;
          end
        end
        ST_RESP: begin
          // rdata moves together with the pulse so a back-to-back hit cannot disturb it.
          rdata    <= resp_byte;
          rdata_en <= 1'b1;
          state    <= ST_IDLE;
          pend_vld <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (start_go) begin
        mem_address <= start_addr[BYTE_ADDR_W-1:1];
        cur_odd     <= start_addr[0];
        tmo_cnt     <= '0;
        if (cache_hit) begin
          state     <= ST_RESP;
          resp_byte <= cache_byte;
        end else begin
          state   <= ST_REQ;
          mem_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ip_ram_read_server.sv
// Directed scoreboard bench for ip_ram_read_server; cache expectations follow IP_RAM_READ_SERVER_CACHE_EN.
`timescale 1ns/1ps
module tb_ip_ram_read_server;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        rd = 1'b0;
  logic        busy;
  logic [21:0] address = '0;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [20:0] mem_address;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;

  ip_ram_read_server dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .rd              (rd),
    .busy            (busy),
    .address         (address),
    .rdata           (rdata),
    .rdata_en        (rdata_en),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .mem_address     (mem_address),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t exp_q[$];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_req_cnt = 0;
  int          en_cnt = 0;
  logic        mem_req_q = 1'b0;
  logic [20:0] last_mem_addr = '0;
  bit          resp_en = 1'b1;
  bit          late_pulse = 1'b0;
  bit          ack_d = 1'b0;
  logic [20:0] acked_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] word_of(input logic [20:0] wa);
    if (wa == 21'h180000) return 16'hA55A;
    return {wa[7:0] ^ 8'h3C, wa[7:0]};
  endfunction

  // Memory responder: ack one cycle after mem_req is seen, data one cycle after ack.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata_valid = 1'b0;
      if (late_pulse) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = 16'hDEAD;
        late_pulse = 1'b0;
      end else if (ack_d && resp_en) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = word_of(acked_addr);
      end
      ack_d = 1'b0;
      if (mem_req) begin
        mem_ack = 1'b1;
        ack_d = 1'b1;
        acked_addr = mem_address;
      end
    end
  end

  // Monitor: pops the scoreboard on every rdata_en pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mem_req && !mem_req_q) begin
      mem_req_cnt++;
      last_mem_addr = mem_address;
    end
    mem_req_q = mem_req;
    if (rdata_en) begin
      en_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rdata_en: got rdata 0x%0h at cycle %0d, required no pulse", rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rdata", {24'd0, rdata}, {24'd0, e.data});
        check("rdata_en_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd(input logic [21:0] a);
    rd = 1'b1;
    address = a;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin
    int c;
    int m0;
    int e0;
    bit busy_ok;

    tick(3);
    check("reset_mem_req", {31'd0, mem_req}, 0);
    check("reset_mem_address", {11'd0, mem_address}, 0);
    check("reset_rdata", {24'd0, rdata}, 0);
    check("reset_rdata_en", {31'd0, rdata_en}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    n_reset = 1'b1;
    tick(2);

    // Basic odd-byte read with minimum latency
    c = cyc; m0 = mem_req_cnt;
    expect_byte(8'hA5, c + 4);
    pulse_rd(22'h300001);
    tick(6);
    check("basic_mem_address", {11'd0, last_mem_addr}, 32'h180000);
    check("basic_mem_req_count", mem_req_cnt - m0, 1);

    // rd held high for ten cycles is one request
    c = cyc; m0 = mem_req_cnt; e0 = en_cnt;
    expect_byte(8'h80, c + 4);
    rd = 1'b1; address = 22'h000100;
    tick(10);
    rd = 1'b0;
    tick(4);
    check("held_mem_req_count", mem_req_cnt - m0, 1);
    check("held_rdata_en_count", en_cnt - e0, 1);

    // Timeout returns fill byte; a late memory response is ignored
    resp_en = 1'b0;
    c = cyc;
    expect_byte(8'hFF, c + 66);
    pulse_rd(22'h000005);
    tick(70);
    check("timeout_mem_req_low", {31'd0, mem_req}, 0);
    e0 = en_cnt;
    late_pulse = 1'b1;
    tick(4);
    check("late_valid_no_pulse", en_cnt - e0, 0);
    check("late_valid_rdata_hold", {24'd0, rdata}, 32'hFF);
    check("late_valid_busy", {31'd0, busy}, 0);
    resp_en = 1'b1;

    // Second edge during WAIT is served after RESP
    c = cyc; m0 = mem_req_cnt;
    expect_byte(8'h10, c + 4);
    expect_byte(8'h1D, c + 7);
    busy_ok = 1'b1;
    rd = 1'b1; address = 22'h000020;
    tick(1); busy_ok &= busy; rd = 1'b0;
    tick(1); busy_ok &= busy; rd = 1'b1; address = 22'h000043;
    tick(1); busy_ok &= busy; rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      busy_ok &= busy;
    end
    check("pend_wait_busy_throughout", {31'd0, busy_ok}, 1);
    tick(3);
    check("pend_wait_busy_after", {31'd0, busy}, 0);
    check("pend_wait_mem_req_count", mem_req_cnt - m0, 2);

    // Edge landing in the RESP cycle is served straight after it
    c = cyc; m0 = mem_req_cnt;
    expect_byte(8'h12, c + 4);
    expect_byte(8'h1F, c + 7);
    busy_ok = 1'b1;
    rd = 1'b1; address = 22'h000024;
    tick(1); busy_ok &= busy; rd = 1'b0;
    tick(2); busy_ok &= busy; rd = 1'b1; address = 22'h000047;
    tick(1); busy_ok &= busy; rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      busy_ok &= busy;
    end
    check("pend_resp_busy_throughout", {31'd0, busy_ok}, 1);
    tick(4);
    check("pend_resp_mem_req_count", mem_req_cnt - m0, 2);

    // Reset during WAIT abandons the read; next read works
    e0 = en_cnt;
    pulse_rd(22'h000200);
    tick(1);
    #1;
    n_reset = 1'b0;
    #1;
    check("midreset_mem_req", {31'd0, mem_req}, 0);
    check("midreset_mem_address", {11'd0, mem_address}, 0);
    check("midreset_rdata", {24'd0, rdata}, 0);
    check("midreset_rdata_en", {31'd0, rdata_en}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    tick(3);
    n_reset = 1'b1;
    tick(2);
    check("midreset_no_pulse", en_cnt - e0, 0);
    c = cyc;
    expect_byte(8'hBC, c + 4);
    pulse_rd(22'h000301);
    tick(6);
    check("post_reset_mem_address", {11'd0, last_mem_addr}, 32'h180);

    // Adjacent bytes of one word
    c = cyc; m0 = mem_req_cnt;
    expect_byte(8'h08, c + 4);
    pulse_rd(22'h000010);
    tick(6);
    c = cyc;
`ifdef IP_RAM_READ_SERVER_CACHE_EN
    expect_byte(8'h34, c + 2);
`else
    expect_byte(8'h34, c + 4);
`endif
    pulse_rd(22'h000011);
    tick(6);
`ifdef IP_RAM_READ_SERVER_CACHE_EN
    check("pair_mem_req_count", mem_req_cnt - m0, 1);
`else
    check("pair_mem_req_count", mem_req_cnt - m0, 2);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ip_ram_read_server.md
IP_RAM_READ_SERVER -- requirements
Module: ip_ram_read_server

Interface
REQ-001 Parameter: timeout_cycles, default 8'd64, max cycles from mem_req assertion to mem_rdata_valid before abort.
REQ-002 Parameter: fill_byte, default 8'hFF, data returned on timeout.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 n_reset  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on posedge.
REQ-006 rd  input  1  client byte-read request level; may stay high several cycles.
REQ-007 busy  output  1  high while a request is in progress or pending.
REQ-008 address  input  22  client byte address.
REQ-009 rdata  output  8  returned byte; holds last value.
REQ-010 rdata_en  output  1  one-cycle pulse marking rdata valid.
REQ-011 mem_req  output  1  word-read request to memory; held until mem_ack.
REQ-012 mem_ack  input  1  memory accepted the request (sampled only while mem_req=1).
REQ-013 mem_address  output  21  word address = address[21:1] of the served request.
REQ-014 mem_rdata  input  16  memory word; [7:0] = even byte, [15:8] = odd byte.
REQ-015 mem_rdata_valid  input  1  one-cycle pulse marking mem_rdata valid.

Function
REQ-016 A request SHALL be a rising edge of rd (rd=1, registered rd=0); address is captured in that cycle.
REQ-017 States SHALL be IDLE, REQ, WAIT, RESP.
REQ-018 IDLE + request -> REQ, mem_req=1 and mem_address valid from the next cycle.
REQ-019 REQ: mem_req held; mem_ack=1 -> WAIT, mem_req=0 the next cycle.
REQ-020 WAIT: mem_rdata_valid=1 -> RESP, selected byte (address[0]) registered into rdata.
REQ-021 RESP: rdata_en=1 for exactly one cycle, then IDLE (or REQ if a request is pending).
REQ-022 Minimum latency with mem_ack and mem_rdata_valid each one cycle after previous step: request cycle N -> rdata_en at N+4.
REQ-023 A timeout counter SHALL start on entry to REQ and count in REQ and WAIT; at timeout_cycles -> RESP with rdata=fill_byte, mem_req=0.
REQ-024 mem_rdata_valid arriving outside WAIT (late response after timeout) SHALL be ignored.
REQ-025 A rising edge of rd while busy=1 SHALL set a one-deep pending flag with its address; further edges while pending SHALL overwrite the pending address.
REQ-026 busy SHALL equal (state != IDLE) OR pending, registered.
REQ-027 Request edge and RESP in the same cycle: request becomes pending and is served directly after RESP.

Reset
REQ-028 On n_reset=0: state IDLE, mem_req=0, mem_address=0, rdata=8'h00, rdata_en=0, busy=0, pending cleared, timeout counter 0, cache invalid.
REQ-029 Reset mid-transaction SHALL abandon it with no rdata_en pulse; post-reset memory responses are ignored per REQ-024.

Configuration
REQ-030 Macro IP_RAM_READ_SERVER_CACHE_EN SHALL enable a one-word cache (21-bit tag, 16-bit data, valid bit).
REQ-031 With it: request whose address[21:1] matches a valid tag -> RESP directly, rdata_en at N+2, no mem_req; cache fills on every WAIT completion, never on timeout.
REQ-032 Without it: every request goes to memory; no cache registers exist.

Structure
REQ-033 Package ip_ram_read_server_pkg SHALL hold the state enum and width constants (22-bit byte address, 21-bit word address, 16-bit word).
REQ-034 Single module; no sub-module.

Verification
REQ-035 Read addr 22'h300001, mem_rdata=16'hA55A, ack/valid one cycle each -> rdata=8'hA5, rdata_en pulse at N+4, mem_address=21'h180000.
REQ-036 rd held high 10 cycles -> exactly one mem_req and one rdata_en.
REQ-037 No mem_rdata_valid -> rdata=8'hFF at timeout_cycles after REQ entry; later valid pulse ignored.
REQ-038 Second rd edge during WAIT -> pending served after RESP; two rdata_en pulses in order, busy high throughout.
REQ-039 n_reset low during WAIT -> all outputs at reset values, no rdata_en, next request served normally.
REQ-040 With cache: reads 22'h000010 then 22'h000011 -> one mem_req; second returns upper byte at N+2.
